// File: rtl/glyph_banner_ctrl_pkg.sv
// Shared definitions for the sliding message banner: FSM encoding,
// message identifiers, glyph character codes and screen geometry.
package glyph_banner_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTER = 2'd1,
      ST_HOLD  = 2'd2,
      ST_EXIT  = 2'd3
   } state_t;

   localparam logic [1:0] MSG_PAUSE     = 2'd0;
   localparam logic [1:0] MSG_GAME_OVER = 2'd1;
   localparam logic [1:0] MSG_READY     = 2'd2;
   localparam logic [1:0] MSG_LEVEL_UP  = 2'd3;

   // Character codes: letters are their alphabet index (A=0 .. Z=25).
   localparam logic [4:0] CH_A     = 5'd0;
   localparam logic [4:0] CH_D     = 5'd3;
   localparam logic [4:0] CH_E     = 5'd4;
   localparam logic [4:0] CH_G     = 5'd6;
   localparam logic [4:0] CH_L     = 5'd11;
   localparam logic [4:0] CH_M     = 5'd12;
   localparam logic [4:0] CH_O     = 5'd14;
   localparam logic [4:0] CH_P     = 5'd15;
   localparam logic [4:0] CH_R     = 5'd17;
   localparam logic [4:0] CH_S     = 5'd18;
   localparam logic [4:0] CH_U     = 5'd20;
   localparam logic [4:0] CH_V     = 5'd21;
   localparam logic [4:0] CH_Y     = 5'd24;
   localparam logic [4:0] CH_SPACE = 5'd31;

   localparam int CELL_W   = 32;
   localparam int CELL_H   = 40;
   localparam int SCREEN_W = 640;

   // Left edge of a centred banner of len cells.
   function automatic logic [9:0] banner_left(input logic [3:0] len);
      return 10'((SCREEN_W - (int'(len) * CELL_W)) / 2);
   endfunction

endpackage

// File: rtl/glyph_msg_rom.sv
// Message text ROM: returns the character at a slot and the message length.
// Slots past the end of a message read back as space.
module glyph_msg_rom
   import glyph_banner_ctrl_pkg::*;
(
   input  logic [1:0] msg_id,
   input  logic [2:0] slot,
   output logic [4:0] code,
   output logic [3:0] len
);

   logic [7:0][4:0] text;

   // Select the message text and length, then pick the addressed slot
   always_comb begin
      text = {8{CH_SPACE}};
      len  = 4'd5;
      case (msg_id)
         MSG_PAUSE: begin
            len = 4'd5;
            text[0] = CH_P; text[1] = CH_A; text[2] = CH_U; text[3] = CH_S;
            text[4] = CH_E;
         end
         MSG_GAME_OVER: begin
            len = 4'd8;
            text[0] = CH_G; text[1] = CH_A; text[2] = CH_M; text[3] = CH_E;
            text[4] = CH_O; text[5] = CH_V; text[6] = CH_E; text[7] = CH_R;
         end
         MSG_READY: begin
            len = 4'd5;
            text[0] = CH_R; text[1] = CH_E; text[2] = CH_A; text[3] = CH_D;
            text[4] = CH_Y;
         end
         default: begin
            len = 4'd8;
            text[0] = CH_L; text[1] = CH_E; text[2] = CH_V; text[3] = CH_E;
            text[4] = CH_L; text[5] = CH_SPACE; text[6] = CH_U; text[7] = CH_P;
         end
      endcase
      code = text[slot];
   end

endmodule

// File: rtl/glyph_banner_ctrl.sv
// Sliding text banner controller: a message slides up from START_Y to
// TARGET_Y, rests (blinking) for HOLD_FRAMES frames, then slides back out.
// Per-pixel glyph cell lookup is combinational from x/y and registered state.
//
// Request handshake: a request is accepted on a clk edge where msg_valid and
// msg_ready are both high; msg_ready is high only while idle, and requests
// presented while busy are dropped, not queued.
module glyph_banner_ctrl
   import glyph_banner_ctrl_pkg::*;
#(
   parameter int START_Y     = 480,
   parameter int TARGET_Y    = 200,
   parameter int STEP        = 4,
   parameter int HOLD_FRAMES = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       msg_valid,
   input  logic [1:0] msg_id,
   output logic       msg_ready,
   input  logic       msg_abort,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic [9:0] cell_x0,
   output logic [9:0] cell_y0,
   output logic [4:0] glyph_code,
   output logic       glyph_en,
   output logic       busy,
   output logic [1:0] dbg_state
);

   localparam logic [9:0] START_Y_V  = 10'(START_Y);
   localparam logic [9:0] TARGET_Y_V = 10'(TARGET_Y);
   localparam logic [9:0] STEP_V     = 10'(STEP);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

   state_t     state;
   logic [7:0] hold_cnt;
   logic [1:0] msg_q;

   logic [9:0] y_dn, y_up;
   logic [3:0] len;
   logic [4:0] rom_code;
   logic [2:0] slot;
   logic [9:0] banner_x0, span;
   logic       in_x, in_y, blink_off;

   // Next banner row for one slide step, clamped at the travel limits
   assign y_dn = ({1'b0, cell_y0} >= 11'(TARGET_Y + STEP)) ? cell_y0 - STEP_V : TARGET_Y_V;
   assign y_up = ({1'b0, cell_y0} + 11'(STEP) >= 11'(START_Y)) ? START_Y_V : cell_y0 + STEP_V;

   // Banner FSM: moves only on frame ticks; handshake and abort act immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cell_y0  <= START_Y_V;
         hold_cnt <= '0;
         msg_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (msg_valid) begin
                  msg_q   <= msg_id;
                  cell_y0 <= START_Y_V;
                  state   <= ST_ENTER;
               end
            end
            ST_ENTER: begin
               if (msg_abort) begin
                  state <= ST_EXIT;
               end else if (frame_tick) begin
                  cell_y0 <= y_dn;
                  if (y_dn == TARGET_Y_V) begin
                     hold_cnt <= '0;
                     state    <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (msg_abort) begin
                  state <= ST_EXIT;
               end else if (frame_tick) begin
                  hold_cnt <= hold_cnt + 8'd1;
                  if (hold_cnt == HOLD_LAST) state <= ST_EXIT;
               end
            end
            ST_EXIT: begin
               if (frame_tick) begin
                  cell_y0 <= y_up;
                  if (y_up == START_Y_V) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   glyph_msg_rom u_rom (
      .msg_id (msg_q),
      .slot   (slot),
      .code   (rom_code),
      .len    (len)
   );

   assign banner_x0 = banner_left(len);
   assign span      = 10'({len, 5'd0});
   assign slot      = 3'((x - banner_x0) >> 5);
   assign in_x      = (x >= banner_x0) && (x < banner_x0 + span);
   assign in_y      = ({1'b0, y} >= {1'b0, cell_y0}) &&
                      ({1'b0, y} <  {1'b0, cell_y0} + 11'(CELL_H));
   // Blink: during the rest phase the banner is hidden on odd 8-frame groups
   assign blink_off = (state == ST_HOLD) && hold_cnt[3];

   assign cell_x0    = in_x ? banner_x0 + {2'b00, slot, 5'd0} : banner_x0;
   assign glyph_code = in_x ? rom_code : CH_SPACE;
   assign glyph_en   = busy && in_x && in_y && !blink_off && (glyph_code != CH_SPACE);

   assign busy      = (state != ST_IDLE);
   assign msg_ready = (state == ST_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_glyph_banner_ctrl.sv
// Bench for glyph_banner_ctrl: directed scenarios followed by random traffic,
// every cycle checked against a text-level reference model through a queue.
`timescale 1ns/1ps
module tb_glyph_banner_ctrl;
   import glyph_banner_ctrl_pkg::*;

   localparam int START_Y     = 480;
   localparam int TARGET_Y    = 200;
   localparam int STEP        = 4;
   localparam int HOLD_FRAMES = 120;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       msg_valid = 1'b0;
   logic [1:0] msg_id = 2'd0;
   logic       msg_abort = 1'b0;
   logic [9:0] x = 10'd300;
   logic [9:0] y = 10'd300;
   logic       msg_ready, glyph_en, busy;
   logic [9:0] cell_x0, cell_y0;
   logic [4:0] glyph_code;
   logic [1:0] dbg_state;

   glyph_banner_ctrl #(
      .START_Y(START_Y), .TARGET_Y(TARGET_Y), .STEP(STEP), .HOLD_FRAMES(HOLD_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .msg_valid(msg_valid),
      .msg_id(msg_id), .msg_ready(msg_ready), .msg_abort(msg_abort),
      .x(x), .y(y), .cell_x0(cell_x0), .cell_y0(cell_y0),
      .glyph_code(glyph_code), .glyph_en(glyph_en), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / counters
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [29:0] exp_q[$];
   logic [9:0] drv_x = 10'd300;
   logic [9:0] drv_y = 10'd300;

   // reference model: banner phase, top row, hold frame count, message text
   typedef enum {P_IDLE, P_ENTER, P_HOLD, P_EXIT} phase_e;
   phase_e m_phase = P_IDLE;
   int m_y = START_Y;
   int m_hold = 0;
   int m_msg = 0;
   string texts[4] = '{"PAUSE", "GAMEOVER", "READY", "LEVEL UP"};

   function automatic logic [1:0] phase_code(phase_e p);
      case (p)
         P_IDLE:  return ST_IDLE;
         P_ENTER: return ST_ENTER;
         P_HOLD:  return ST_HOLD;
         default: return ST_EXIT;
      endcase
   endfunction

   function automatic logic [29:0] model_outputs(int px, int py);
      string s;
      int    len, bx0, slot, code, cx0;
      byte   c;
      bit    inx, iny, bsy, blink, en;
      s    = texts[m_msg];
      len  = s.len();
      bx0  = (640 - len * 32) / 2;
      inx  = (px >= bx0) && (px < bx0 + len * 32);
      code = 31;
      cx0  = bx0;
      if (inx) begin
         slot = (px - bx0) / 32;
         cx0  = bx0 + slot * 32;
         c    = s[slot];
         code = (c == 8'd32) ? 31 : int'(c) - 65;
      end
      bsy   = (m_phase != P_IDLE);
      iny   = (py >= m_y) && (py < m_y + 40);
      blink = (m_phase == P_HOLD) && ((m_hold / 8) % 2 == 1);
      en    = bsy && inx && iny && !blink && (code != 31);
      return {phase_code(m_phase), bsy, !bsy, 10'(m_y), 10'(cx0), 5'(code), en};
   endfunction

   task automatic model_step();
      if (rst) begin
         m_phase = P_IDLE; m_y = START_Y; m_hold = 0; m_msg = 0;
      end else begin
         case (m_phase)
            P_IDLE:
               if (msg_valid) begin
                  m_msg = int'(msg_id); m_y = START_Y; m_phase = P_ENTER;
               end
            P_ENTER:
               if (msg_abort) m_phase = P_EXIT;
               else if (frame_tick) begin
                  m_y = (m_y - STEP > TARGET_Y) ? m_y - STEP : TARGET_Y;
                  if (m_y == TARGET_Y) begin m_hold = 0; m_phase = P_HOLD; end
               end
            P_HOLD:
               if (msg_abort) m_phase = P_EXIT;
               else if (frame_tick) begin
                  if (m_hold == HOLD_FRAMES - 1) m_phase = P_EXIT;
                  m_hold = (m_hold + 1) % 256;
               end
            default:
               if (frame_tick) begin
                  m_y = (m_y + STEP < START_Y) ? m_y + STEP : START_Y;
                  if (m_y == START_Y) m_phase = P_IDLE;
               end
         endcase
      end
   endtask

   // driver: one clock cycle of stimulus; expected outputs queued after the edge
   task automatic cyc(input bit tick, input bit valid, input logic [1:0] id,
                      input bit abort, input bit r);
      @(negedge clk);
      #1;
      frame_tick = tick; msg_valid = valid; msg_id = id; msg_abort = abort;
      rst = r; x = drv_x; y = drv_y;
      @(posedge clk);
      model_step();
      exp_q.push_back(model_outputs(int'(drv_x), int'(drv_y)));
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // scoreboard monitor: compare every presented cycle against the queue
   always @(negedge clk) begin
      logic [29:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {dbg_state, busy, msg_ready, cell_y0, cell_x0, glyph_code, glyph_en};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL cycle_outputs @%0t: got st=%0d busy=%b rdy=%b y0=%0d x0=%0d code=%0d en=%b, expected st=%0d busy=%b rdy=%b y0=%0d x0=%0d code=%0d en=%b",
                     $time, a[29:28], a[27], a[26], a[25:16], a[15:6], a[5:1], a[0],
                     e[29:28], e[27], e[26], e[25:16], e[15:6], e[5:1], e[0]);
         end
      end
   end

   // stimulus
   initial begin
      int yy;
      cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      check("reset_ready", int'(msg_ready), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_y0", int'(cell_y0), 480);
      check("reset_en", int'(glyph_en), 0);

      // GAME OVER slides in over exactly 70 ticks
      cyc(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
      check("hs_busy", int'(busy), 1);
      check("hs_state", int'(dbg_state), int'(ST_ENTER));
      ticks(69);
      check("enter69_y0", int'(cell_y0), 204);
      check("enter69_state", int'(dbg_state), int'(ST_ENTER));
      ticks(1);
      check("enter70_y0", int'(cell_y0), 200);
      check("enter70_state", int'(dbg_state), int'(ST_HOLD));

      drv_x = 10'd230; drv_y = 10'd210;
      ticks(2);
      check("hold2_x0", int'(cell_x0), 224);
      check("hold2_code", int'(glyph_code), 0);
      check("hold2_en", int'(glyph_en), 1);

      cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
      check("hold_req_ready", int'(msg_ready), 0);
      ticks(6);
      check("blink8_en", int'(glyph_en), 0);
      check("blink8_code_kept", int'(glyph_code), 0);
      ticks(8);
      check("blink16_en", int'(glyph_en), 1);
      ticks(103);
      check("hold_end_state", int'(dbg_state), int'(ST_HOLD));
      ticks(1);
      check("exit_state", int'(dbg_state), int'(ST_EXIT));
      check("exit_y0", int'(cell_y0), 200);
      ticks(70);
      check("out_state", int'(dbg_state), int'(ST_IDLE));
      check("out_ready", int'(msg_ready), 1);
      check("out_y0", int'(cell_y0), 480);

      // abort coincident with a tick at row 300
      cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      ticks(45);
      check("pre_abort_y0", int'(cell_y0), 300);
      cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
      check("abort_state", int'(dbg_state), int'(ST_EXIT));
      check("abort_y0", int'(cell_y0), 300);
      ticks(1);
      check("abort_next_y0", int'(cell_y0), 304);
      ticks(24);
      drv_x = 10'd300; drv_y = 10'd405;
      cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      check("exit400_y0", int'(cell_y0), 400);
      check("exit400_en", int'(glyph_en), 1);
      cyc(1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
      check("rst_exit_state", int'(dbg_state), int'(ST_IDLE));
      check("rst_exit_y0", int'(cell_y0), 480);
      check("rst_exit_en", int'(glyph_en), 0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         drv_x = 10'($urandom_range(150, 500));
         yy = m_y - 5 + int'($urandom_range(0, 50));
         if (yy < 0) yy = 0;
         drv_y = 10'(yy);
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
             2'($urandom_range(0, 3)), $urandom_range(0, 299) == 0,
             $urandom_range(0, 1999) == 0);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
